// File: rtl/prefix_sum_stage_if.sv
// Handshake and datapath bundle for the prefix-adder sum stage.
// The master drives beats and out_ready; the slave is the stage.
interface prefix_sum_stage_if #(
   parameter int unsigned W = 64
);
   localparam int unsigned NSEG = W / 8;

   logic            in_valid;
   logic            in_ready;
   logic [1:0]      mode;
   logic            cin;
   logic [W-1:0]    p_bit;
   logic [W-1:0]    g_grp;
   logic [W-1:0]    p_grp;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    sum;
   logic [NSEG-1:0] cout;
   logic [NSEG-1:0] ovf;
   logic [NSEG-1:0] zero;

   modport master (
      output in_valid, mode, cin, p_bit, g_grp, p_grp, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, mode, cin, p_bit, g_grp, p_grp, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/prefix_sum_stage.sv
// Sum stage of the SIMD parallel-prefix adder: forms lane sums and per-lane
// carry/overflow/zero flags, then registers them behind a 2-entry skid buffer.
module prefix_sum_stage #(
   parameter int unsigned W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   prefix_sum_stage_if.slave    bus
);
   localparam int unsigned NSEG = W / 8;
   localparam int unsigned BW   = W + 3 * NSEG;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [BW-1:0]   main_q, main_d;
   logic [BW-1:0]   skid_q, skid_d;

   logic [W-1:0]    c;
   logic [W-1:0]    sum_c;
   logic [NSEG-1:0] segz;
   logic [NSEG-1:0] cout_c, ovf_c, zero_c;
   logic [BW-1:0]   beat_c;
   int unsigned     lw;
   int unsigned     segs;
   logic            accept, release_w;

   always_comb begin
      lw   = 32'd8 << bus.mode;
      segs = 32'd1 << bus.mode;
      c    = '0;
      c[0] = bus.cin;
      for (int unsigned i = 1; i < W; i++)
         c[i] = ((i & (lw - 1)) == 0) ? bus.cin
                                      : (bus.g_grp[i-1] | (bus.p_grp[i-1] & bus.cin));
      sum_c = bus.p_bit ^ c;
      for (int unsigned s = 0; s < NSEG; s++)
         segz[s] = ~|sum_c[8*s +: 8];
      cout_c = '0;
      ovf_c  = '0;
      zero_c = '0;
      // Flags live only at the lane's top segment; zero folds every segment of that lane.
      for (int unsigned s = 0; s < NSEG; s++) begin
         if (((s + 1) & (segs - 1)) == 0) begin
            cout_c[s] = bus.g_grp[8*s+7] | (bus.p_grp[8*s+7] & bus.cin);
            ovf_c[s]  = c[8*s+7] ^ cout_c[s];
            zero_c[s] = 1'b1;
            for (int unsigned k = 0; k < NSEG; k++)
               if ((k >> bus.mode) == (s >> bus.mode))
                  zero_c[s] = zero_c[s] & segz[k];
         end
      end
   end

   assign beat_c = {sum_c, cout_c, ovf_c, zero_c};

   // in_ready depends only on registered state (and reset), never on out_ready.
   assign bus.in_ready  = rst_n & (state_q != FULL);
   assign bus.out_valid = (state_q != EMPTY);
   assign {bus.sum, bus.cout, bus.ovf, bus.zero} = main_q;

   assign accept    = bus.in_valid & bus.in_ready;
   assign release_w = bus.out_valid & bus.out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = beat_c;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && !release_w) begin
               skid_d  = beat_c;
               state_d = FULL;
            end else if (accept && release_w) begin
               main_d  = beat_c;
            end else if (release_w) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (release_w) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: tb/tb_prefix_sum_stage.sv
// Bench for prefix_sum_stage: operand-level vectors turned into P/G inputs,
// expected lane results queued on accept and compared on release.
module tb_prefix_sum_stage;
   localparam int unsigned W    = 64;
   localparam int unsigned NSEG = 8;

   typedef struct {
      logic [63:0] sum;
      logic [7:0]  cout;
      logic [7:0]  ovf;
      logic [7:0]  zero;
   } exp_t;

   typedef struct {
      logic [1:0]  mode;
      logic        cin;
      logic [63:0] a;
      logic [63:0] b;
      exp_t        e;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   prefix_sum_stage_if #(.W(W)) bus ();
   prefix_sum_stage #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] mode, input logic cin,
                                  input logic [63:0] a, input logic [63:0] b);
      exp_t        e;
      int unsigned lw, nl, segs, top;
      logic [64:0] s;
      logic [63:0] mask, al, bl, sl;
      e.sum = '0; e.cout = '0; e.ovf = '0; e.zero = '0;
      lw   = 8 << mode;
      nl   = 64 / lw;
      segs = lw / 8;
      mask = (lw == 64) ? '1 : ((64'd1 << lw) - 64'd1);
      for (int unsigned l = 0; l < nl; l++) begin
         al  = (a >> (l * lw)) & mask;
         bl  = (b >> (l * lw)) & mask;
         s   = {1'b0, al} + {1'b0, bl} + {64'd0, cin};
         sl  = s[63:0] & mask;
         top = (l + 1) * segs - 1;
         e.sum       = e.sum | (sl << (l * lw));
         e.cout[top] = s[lw];
         e.ovf[top]  = (al[lw-1] == bl[lw-1]) && (sl[lw-1] != al[lw-1]);
         e.zero[top] = (sl == 64'd0);
      end
      return e;
   endfunction

   task automatic make_pg(input logic [1:0] mode, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] pb, output logic [63:0] gg, output logic [63:0] pp);
      int unsigned lw;
      logic g, p;
      lw = 8 << mode;
      g = 1'b0; p = 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
         if ((i % lw) == 0) begin
            g = a[i] & b[i];
            p = a[i] ^ b[i];
         end else begin
            g = (a[i] & b[i]) | ((a[i] ^ b[i]) & g);
            p = (a[i] ^ b[i]) & p;
         end
         pb[i] = a[i] ^ b[i];
         gg[i] = g;
         pp[i] = p;
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sbq.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_beat: got out_valid=1 expected no pending beat");
      end else begin
         e = sbq.pop_front();
         chk("sum",  bus.sum,        e.sum);
         chk("cout", {56'd0, bus.cout}, {56'd0, e.cout});
         chk("ovf",  {56'd0, bus.ovf},  {56'd0, e.ovf});
         chk("zero", {56'd0, bus.zero}, {56'd0, e.zero});
      end
   endtask

   // Called at a falling edge: drives one cycle, scores the upcoming rising edge.
   task automatic drive(input logic v, input logic [1:0] mode, input logic cin,
                        input logic [63:0] a, input logic [63:0] b, input exp_t e,
                        input logic ordy, output logic acc);
      logic [63:0] pb, gg, pp;
      make_pg(mode, a, b, pb, gg, pp);
      bus.in_valid  = v;
      bus.mode      = mode;
      bus.cin       = cin;
      bus.p_bit     = pb;
      bus.g_grp     = gg;
      bus.p_grp     = pp;
      bus.out_ready = ordy;
      #1;
      acc = v & bus.in_ready;
      if (bus.out_valid && bus.out_ready) check_out();
      if (acc) sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      logic  acc;
      exp_t  e;
      logic [63:0] a, b;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      e = model(2'd0, 1'b0, a, b);
      drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b, e, ordy, acc);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sbq.size() != 0; i++) idle(1'b1);
      chk("drain_empty", 64'(sbq.size()), 64'd0);
   endtask

   vec_t vt[7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc, acc1, acc2, acc3;
      logic [1:0]  m;
      logic        ci;
      logic [63:0] a, b;
      int          got, cyc;

      vt[0] = '{2'b00, 1'b0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0001,
                '{64'h0, 8'h01, 8'h00, 8'hFF}};
      vt[1] = '{2'b11, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                '{64'h8000_0000_0000_0000, 8'h00, 8'h80, 8'h00}};
      vt[2] = '{2'b10, 1'b1, 64'h0000_0005_0000_0005, 64'hFFFF_FFFA_FFFF_FFFA,
                '{64'h0, 8'h88, 8'h00, 8'h88}};
      vt[3] = '{2'b01, 1'b0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001,
                '{64'h8000_8000_8000_8000, 8'h00, 8'hAA, 8'h00}};
      vt[4] = '{2'b00, 1'b0, 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
                '{64'h0, 8'hFF, 8'hFF, 8'hFF}};
      vt[5] = '{2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                '{64'h0, 8'h80, 8'h00, 8'h80}};
      vt[6] = '{2'b00, 1'b1, 64'h0102_0304_0506_0708, 64'h1010_1010_1010_1010,
                '{64'h1213_1415_1617_1819, 8'h00, 8'h00, 8'h00}};

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.mode = 2'b00; bus.cin = 1'b0;
      bus.p_bit = '0; bus.g_grp = '0; bus.p_grp = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_sum",       bus.sum, 64'd0);
      chk("rst_flags",     {40'd0, bus.cout, bus.ovf, bus.zero}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

      // table vectors, continuous flow
      foreach (vt[i]) begin
         acc = 1'b0;
         for (int t = 0; t < 20 && !acc; t++)
            drive(1'b1, vt[i].mode, vt[i].cin, vt[i].a, vt[i].b, vt[i].e, 1'b1, acc);
         chk("tbl_accept", 64'(acc), 64'd1);
      end
      drain();

      // backpressure: three back-to-back beats with out_ready low
      a = 64'h1111_2222_3333_4444; b = 64'h0F0F_0F0F_F0F0_F0F0;
      drive(1'b1, 2'b00, 1'b0, a, b, model(2'b00, 1'b0, a, b), 1'b0, acc1);
      drive(1'b1, 2'b01, 1'b1, b, a, model(2'b01, 1'b1, b, a), 1'b0, acc2);
      #1;
      chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
      drive(1'b1, 2'b10, 1'b0, a, a, model(2'b10, 1'b0, a, a), 1'b0, acc3);
      chk("bp_acc1", 64'(acc1), 64'd1);
      chk("bp_acc2", 64'(acc2), 64'd1);
      chk("bp_acc3", 64'(acc3), 64'd0);
      drain();

      // fill to FULL, then pulse reset between clock edges
      drive(1'b1, 2'b11, 1'b1, a, b, model(2'b11, 1'b1, a, b), 1'b0, acc1);
      drive(1'b1, 2'b00, 1'b0, b, b, model(2'b00, 1'b0, b, b), 1'b0, acc2);
      bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_in_ready",  64'(bus.in_ready), 64'd0);
      sbq.delete();
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      repeat (3) idle(1'b1);
      #1;
      chk("post_rst_no_output", 64'(bus.out_valid), 64'd0);
      @(negedge clk);

      // random traffic with stalls on both sides
      got = 0;
      for (cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
         m  = 2'($urandom_range(0, 3));
         ci = 1'($urandom_range(0, 1));
         a  = {$urandom(), $urandom()};
         b  = {$urandom(), $urandom()};
         drive(($urandom_range(0, 3) != 0), m, ci, a, b, model(m, ci, a, b),
               ($urandom_range(0, 3) != 0), acc);
         if (acc) got++;
      end
      chk("rand_accepted", 64'(got), 64'd10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
